// File: rtl/ctl_resp.sv
// Control-bus responder: decodes read commands from the CPU control channel and
// streams BEATS bytes from a req/ack byte memory back onto the bus data path.
module ctl_resp #(
  parameter logic [7:0] CTL_READ_ADDR = 8'h02,
  parameter int         ADDR_WIDTH    = 17,
  parameter int         BEATS         = 4,
  parameter int         TIMEOUT       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            ctl_op_in,
  input  logic [63:0]           ctl_data_in,
  input  logic [7:0]            mem_rdata_in,
  input  logic                  mem_ack_in,
  output logic                  mem_req_out,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [7:0]            bus_data_out,
  output logic                  bus_valid_out,
  output logic                  bus_err_out,
  output logic                  busy_out,
  output logic                  ctl_drop_out
);

  localparam int IDX_W = 5;

  typedef enum logic {S_IDLE, S_FETCH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  req_q, req_d;
  logic                  busy_q, busy_d;
  logic [7:0]            data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    tmo_d   = tmo_q;
    req_d   = req_q;
    busy_d  = busy_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctl_op_in == CTL_READ_ADDR) begin
          // Addresses beyond the memory range are rejected without touching memory.
          if (ctl_data_in[63:ADDR_WIDTH] == '0) begin
            state_d = S_FETCH;
            base_d  = ctl_data_in[ADDR_WIDTH-1:0];
            addr_d  = ctl_data_in[ADDR_WIDTH-1:0];
            idx_d   = '0;
            tmo_d   = '0;
            req_d   = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else if (ctl_op_in != 8'h00) begin
          err_d = 1'b1;
        end
      end
      S_FETCH: begin
        drop_d = (ctl_op_in != 8'h00);
        // An ack takes priority over a timeout landing on the same edge.
        if (mem_ack_in) begin
          data_d  = mem_rdata_in;
          valid_d = 1'b1;
          idx_d   = idx_q + 5'd1;
          tmo_d   = '0;
          if (idx_q == IDX_W'(BEATS - 1)) begin
            req_d   = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            addr_d = base_q + ADDR_WIDTH'(idx_q) + ADDR_WIDTH'(1);
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
          if (tmo_q == 8'(TIMEOUT - 1)) begin
            req_d   = 1'b0;
            busy_d  = 1'b0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign mem_req_out   = req_q;
  assign mem_addr_out  = addr_q;
  assign bus_data_out  = data_q;
  assign bus_valid_out = valid_q;
  assign bus_err_out   = err_q;
  assign busy_out      = busy_q;
  assign ctl_drop_out  = drop_q;

endmodule
